// File: rtl/aipp_pkg.sv
// Shared AIPP definitions: sequencer state encoding, opcode and default voltage limits.
package aipp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DELAY  = 2'b01,
        RAMP   = 2'b10,
        SETTLE = 2'b11
    } aipp_state_e;

    localparam logic [7:0] AIPP_OP_PRECHARGE = 8'h10;

    localparam int unsigned AIPP_V_MIN_MV = 600;
    localparam int unsigned AIPP_V_MAX_MV = 1200;
    localparam int unsigned AIPP_V_RST_MV = 750;

endpackage

// File: rtl/aipp_us_timer.sv
// Microsecond timer: prescaler plus 32-bit us counter; expire_c flags the last cycle of the interval.
module aipp_us_timer #(
    parameter int unsigned CYC_PER_US = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] limit,
    output logic        expire_c
);
    localparam int unsigned PW = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;

    logic [PW-1:0] pre_q, pre_d;
    logic [31:0]   us_q, us_d;
    logic [31:0]   lim_q, lim_d;
    logic          run_q, run_d;
    logic          wrap;

    // A microsecond closes on prescaler wrap; the interval ends on the wrap that reaches the limit.
    assign wrap     = run_q && (pre_q == PW'(CYC_PER_US - 1));
    assign expire_c = wrap && ((us_q + 32'd1) == lim_q);

    // Next-state: count while running, load restarts from zero, clear stops.
    always_comb begin
        pre_d = pre_q;
        us_d  = us_q;
        lim_d = lim_q;
        run_d = run_q;
        if (run_q) begin
            if (wrap) begin
                pre_d = '0;
                us_d  = us_q + 32'd1;
            end else begin
                pre_d = pre_q + PW'(1);
            end
            if (expire_c) begin
                run_d = 1'b0;
            end
        end
        if (clear) begin
            run_d = 1'b0;
            pre_d = '0;
            us_d  = '0;
        end
        if (load) begin
            run_d = 1'b1;
            pre_d = '0;
            us_d  = '0;
            lim_d = limit;
        end
    end

    // Timer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
            us_q  <= '0;
            lim_q <= '0;
            run_q <= 1'b0;
        end else begin
            pre_q <= pre_d;
            us_q  <= us_d;
            lim_q <= lim_d;
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/aipp_precharge_sequencer.sv
// Pre-charge sequencer: delay, bounded-step VRM setpoint ramp, then wait for power-good.
module aipp_precharge_sequencer
    import aipp_pkg::*;
#(
    parameter int unsigned CYC_PER_US   = 1000,
    parameter int unsigned VSTEP_MV     = 10,
    parameter int unsigned STEP_CYC     = 50,
    parameter int unsigned V_MIN_MV     = AIPP_V_MIN_MV,
    parameter int unsigned V_MAX_MV     = AIPP_V_MAX_MV,
    parameter int unsigned V_RST_MV     = AIPP_V_RST_MV,
    parameter int unsigned MAX_DELAY_US = 10000,
    parameter int unsigned SETTLE_TO_US = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trig_in,
    input  logic [31:0] delay_us,
    input  logic [31:0] voltage_mv,
    input  logic        abort,
    input  logic        vrm_pgood,
    output logic [15:0] vrm_sp_mv,
    output logic        vrm_sp_vld,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        overrun
);
    localparam logic [15:0] VSTEP16   = 16'(VSTEP_MV);
    localparam logic [15:0] STEP_LAST = 16'(STEP_CYC - 1);

    aipp_state_e state_q, state_d;
    logic [15:0] sp_q, sp_d;
    logic [15:0] tgt_q, tgt_d;
    logic [15:0] step_cnt_q, step_cnt_d;
    logic        vld_q, vld_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        ovr_q, ovr_d;

    logic        tmr_load, tmr_clear, tmr_expire_c;
    logic [31:0] tmr_limit;
    logic        cmd_ok, ramp_go, settle_go;
    logic [15:0] diff, step_amt;

    // Both operands are range-checked at full 32-bit width before the target is truncated.
    assign cmd_ok = (delay_us <= 32'(MAX_DELAY_US)) &&
                    (voltage_mv >= 32'(V_MIN_MV)) &&
                    (voltage_mv <= 32'(V_MAX_MV));

    // One timer serves both the commanded delay and the power-good timeout.
    aipp_us_timer #(
        .CYC_PER_US(CYC_PER_US)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .clear   (tmr_clear),
        .limit   (tmr_limit),
        .expire_c(tmr_expire_c)
    );

    // Next-state and output logic; abort is applied last so it overrides completion and steps.
    always_comb begin
        state_d    = state_q;
        sp_d       = sp_q;
        tgt_d      = tgt_q;
        step_cnt_d = step_cnt_q;
        vld_d      = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        ovr_d      = trig_in && (state_q != IDLE);
        busy_d     = 1'b0;
        tmr_load   = 1'b0;
        tmr_clear  = 1'b0;
        tmr_limit  = '0;
        ramp_go    = 1'b0;
        settle_go  = 1'b0;
        diff       = '0;
        step_amt   = '0;

        unique case (state_q)
            IDLE: begin
                if (trig_in) begin
                    if (!cmd_ok) begin
                        err_d = 1'b1;
                    end else begin
                        tgt_d = voltage_mv[15:0];
                        if (delay_us == 32'd0) begin
                            ramp_go = 1'b1;
                        end else begin
                            state_d   = DELAY;
                            tmr_load  = 1'b1;
                            tmr_limit = delay_us;
                        end
                    end
                end
            end
            DELAY: begin
                if (tmr_expire_c) begin
                    tmr_clear = 1'b1;
                    ramp_go   = 1'b1;
                end
            end
            RAMP: begin
                if (step_cnt_q == STEP_LAST) begin
                    step_cnt_d = '0;
                    if (tgt_q > sp_q) begin
                        diff     = tgt_q - sp_q;
                        step_amt = (diff > VSTEP16) ? VSTEP16 : diff;
                        sp_d     = sp_q + step_amt;
                    end else begin
                        diff     = sp_q - tgt_q;
                        step_amt = (diff > VSTEP16) ? VSTEP16 : diff;
                        sp_d     = sp_q - step_amt;
                    end
                    vld_d = 1'b1;
                    if (sp_d == tgt_q) begin
                        settle_go = 1'b1;
                    end
                end else begin
                    step_cnt_d = step_cnt_q + 16'd1;
                end
            end
            SETTLE: begin
                if (vrm_pgood) begin
                    done_d    = 1'b1;
                    state_d   = IDLE;
                    tmr_clear = 1'b1;
                end else if (tmr_expire_c) begin
                    err_d     = 1'b1;
                    state_d   = IDLE;
                    tmr_clear = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Entering the ramp with the setpoint already on target skips straight to settling.
        if (ramp_go) begin
            step_cnt_d = '0;
            if (tgt_d == sp_q) begin
                settle_go = 1'b1;
            end else begin
                state_d = RAMP;
            end
        end

        if (settle_go) begin
            state_d   = SETTLE;
            tmr_load  = 1'b1;
            tmr_limit = 32'(SETTLE_TO_US);
        end

        if (abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            sp_d       = sp_q;
            step_cnt_d = '0;
            vld_d      = 1'b0;
            done_d     = 1'b0;
            err_d      = 1'b0;
            tmr_load   = 1'b0;
            tmr_clear  = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sp_q       <= 16'(V_RST_MV);
            tgt_q      <= '0;
            step_cnt_q <= '0;
            vld_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sp_q       <= sp_d;
            tgt_q      <= tgt_d;
            step_cnt_q <= step_cnt_d;
            vld_q      <= vld_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ovr_q      <= ovr_d;
        end
    end

    assign vrm_sp_mv  = sp_q;
    assign vrm_sp_vld = vld_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_aipp_precharge_sequencer.sv
// Self-checking bench for aipp_precharge_sequencer against a timeline model built from the command rules.
module tb_aipp_precharge_sequencer;

    localparam int C      = 10;
    localparam int VSTEP  = 10;
    localparam int STEP   = 50;
    localparam int VMIN   = 600;
    localparam int VMAX   = 1200;
    localparam int VRST   = 750;
    localparam int MAXD   = 10000;
    localparam int SETTLE = 20;
    localparam int TO     = SETTLE * C;

    logic        clk = 1'b0;
    logic        rst;
    logic        trig_in;
    logic [31:0] delay_us;
    logic [31:0] voltage_mv;
    logic        abort;
    logic        vrm_pgood;
    logic [15:0] vrm_sp_mv;
    logic        vrm_sp_vld;
    logic        busy;
    logic        done;
    logic        err;
    logic        overrun;

    int n_chk  = 0;
    int n_fail = 0;
    int m_sp   = VRST;

    always #5 clk = ~clk;

    aipp_precharge_sequencer #(
        .CYC_PER_US  (C),
        .VSTEP_MV    (VSTEP),
        .STEP_CYC    (STEP),
        .V_MIN_MV    (VMIN),
        .V_MAX_MV    (VMAX),
        .V_RST_MV    (VRST),
        .MAX_DELAY_US(MAXD),
        .SETTLE_TO_US(SETTLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .trig_in   (trig_in),
        .delay_us  (delay_us),
        .voltage_mv(voltage_mv),
        .abort     (abort),
        .vrm_pgood (vrm_pgood),
        .vrm_sp_mv (vrm_sp_mv),
        .vrm_sp_vld(vrm_sp_vld),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .overrun   (overrun)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; trig_in = 1'b0; abort = 1'b0; vrm_pgood = 1'b0;
        delay_us = '0; voltage_mv = '0;
        tick; tick;
        rst = 1'b0;
        m_sp = VRST;
    endtask

    // Issue one command and check every output on every cycle until it has fully retired.
    // pg: cycles after settle entry before pgood is driven (-1 never); ab: cycle to abort; tk: cycle to re-trigger.
    task automatic run_cmd(input string tag, input int d, input int v, input int pg, input int ab, input int tk);
        int  steps_v[$];
        int  st_t[$];
        int  s, base, settle_k, norm_end, end_k, fin;
        bit  legal, aborted;
        legal = (d >= 0) && (d <= MAXD) && (v >= VMIN) && (v <= VMAX);
        trig_in = 1'b1; delay_us = 32'(d); voltage_mv = 32'(v);
        tick;
        trig_in = 1'b0; delay_us = $urandom; voltage_mv = $urandom;
        if (!legal) begin
            n_chk++;
            if ({vrm_sp_vld, busy, done, err, overrun} !== 5'b00010) begin
                n_fail++;
                $display("FAIL %s reject flags {vld,busy,done,err,ovr} got %b want 00010", tag,
                         {vrm_sp_vld, busy, done, err, overrun});
            end
            n_chk++;
            if (vrm_sp_mv !== 16'(m_sp)) begin
                n_fail++;
                $display("FAIL %s reject sp got %0d want %0d", tag, vrm_sp_mv, m_sp);
            end
            tick;
            n_chk++;
            if ({vrm_sp_vld, busy, done, err, overrun} !== 5'b00000) begin
                n_fail++;
                $display("FAIL %s post-reject flags got %b want 00000", tag, {vrm_sp_vld, busy, done, err, overrun});
            end
            return;
        end
        s    = m_sp;
        base = d * C;
        while (s != v) begin
            if (v > s) s = s + (((v - s) > VSTEP) ? VSTEP : (v - s));
            else       s = s - (((s - v) > VSTEP) ? VSTEP : (s - v));
            steps_v.push_back(s);
            st_t.push_back(base + STEP * steps_v.size());
        end
        settle_k = base + STEP * steps_v.size();
        norm_end = (pg >= 0) ? settle_k + pg + 1 : settle_k + TO;
        aborted  = (ab >= 0) && (ab + 1 <= norm_end);
        end_k    = aborted ? ab + 1 : norm_end;
        fin      = m_sp;
        foreach (st_t[j]) if (st_t[j] < end_k) fin = steps_v[j];
        for (int k = 0; k <= end_k + 1; k++) begin
            logic [15:0] e_sp;
            logic        e_vld, e_busy, e_done, e_err, e_ovr;
            e_sp  = 16'(m_sp);
            e_vld = 1'b0;
            foreach (st_t[j]) begin
                if (st_t[j] <= k && st_t[j] < end_k) begin
                    e_sp = 16'(steps_v[j]);
                    if (st_t[j] == k) e_vld = 1'b1;
                end
            end
            e_busy = (k < end_k);
            e_done = !aborted && (pg >= 0) && (k == end_k);
            e_err  = !aborted && (pg < 0) && (k == end_k);
            e_ovr  = (tk >= 0) && (tk < end_k) && (k == tk + 1);
            n_chk++;
            if ({vrm_sp_vld, busy, done, err, overrun} !== {e_vld, e_busy, e_done, e_err, e_ovr}) begin
                n_fail++;
                $display("FAIL %s k=%0d flags {vld,busy,done,err,ovr} got %b want %b", tag, k,
                         {vrm_sp_vld, busy, done, err, overrun}, {e_vld, e_busy, e_done, e_err, e_ovr});
            end
            n_chk++;
            if (vrm_sp_mv !== e_sp) begin
                n_fail++;
                $display("FAIL %s k=%0d sp got %0d want %0d", tag, k, vrm_sp_mv, e_sp);
            end
            trig_in = (k == tk) && (k < end_k);
            if (trig_in) begin
                delay_us   = $urandom_range(0, 5);
                voltage_mv = $urandom_range(VMIN, VMAX);
            end
            abort     = (k == ab);
            vrm_pgood = (pg >= 0) && (k == settle_k + pg);
            tick;
        end
        trig_in = 1'b0; abort = 1'b0; vrm_pgood = 1'b0;
        m_sp = fin;
    endtask

    task automatic test_reset;
        rst = 1'b1; trig_in = 1'b1; delay_us = '0; voltage_mv = 32'd900; abort = 1'b0; vrm_pgood = 1'b0;
        tick; tick;
        n_chk++;
        if ({vrm_sp_vld, busy, done, err, overrun} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset flags got %b want 00000", {vrm_sp_vld, busy, done, err, overrun});
        end
        n_chk++;
        if (vrm_sp_mv !== 16'(VRST)) begin
            n_fail++;
            $display("FAIL reset sp got %0d want %0d", vrm_sp_mv, VRST);
        end
        rst = 1'b0; trig_in = 1'b0;
        tick;
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_trig busy got %b want 0", busy);
        end
        m_sp = VRST;
    endtask

    task automatic test_basic;
        run_cmd("basic_750_800", 3, 800, 7, -1, -1);
    endtask

    task automatic test_odd_step;
        do_reset;
        run_cmd("odd_750_785", 0, 785, 2, -1, -1);
        run_cmd("down_785_600", 0, 600, 0, -1, -1);
    endtask

    task automatic test_range;
        run_cmd("v1201", 0, 1201, 0, -1, -1);
        run_cmd("v599", 2, 599, 0, -1, -1);
        run_cmd("dmax_plus1", MAXD + 1, 800, 0, -1, -1);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        n_chk++;
        if ({vrm_sp_vld, busy, done, err, overrun} !== 5'b00000 || vrm_sp_mv !== 16'(m_sp)) begin
            n_fail++;
            $display("FAIL abort_idle flags/sp got %b/%0d want 00000/%0d",
                     {vrm_sp_vld, busy, done, err, overrun}, vrm_sp_mv, m_sp);
        end
        run_cmd("v1200_d0", 0, 1200, 3, -1, -1);
        run_cmd("dmax_abort", MAXD, 700, -1, 20, -1);
        run_cmd("equal_target", 1, 1200, 4, -1, -1);
    endtask

    task automatic test_timeout;
        run_cmd("timeout", 0, 1180, -1, -1, -1);
        run_cmd("pgood_tie", 0, 1170, TO - 1, -1, -1);
    endtask

    task automatic test_abort;
        do_reset;
        run_cmd("abort_ramp", 1, 900, -1, C + 2 * STEP, -1);
        run_cmd("abort_vs_done", 0, 790, 5, 2 * STEP + 5, -1);
    endtask

    task automatic test_overrun;
        run_cmd("overrun", 2, 700, 5, -1, 15);
        run_cmd("overrun_abort", 1, 760, -1, 30, 30);
    endtask

    task automatic test_rst_mid_delay;
        trig_in = 1'b1; delay_us = 32'd3; voltage_mv = 32'd900;
        tick;
        trig_in = 1'b0;
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid busy_before got %b want 1", busy);
        end
        repeat (12) tick;
        rst = 1'b1;
        tick;
        n_chk++;
        if ({vrm_sp_vld, busy, done, err, overrun} !== 5'b00000 || vrm_sp_mv !== 16'(VRST)) begin
            n_fail++;
            $display("FAIL rst_mid flags/sp got %b/%0d want 00000/%0d",
                     {vrm_sp_vld, busy, done, err, overrun}, vrm_sp_mv, VRST);
        end
        rst = 1'b0;
        repeat (100) tick;
        n_chk++;
        if ({vrm_sp_vld, busy, done, err, overrun} !== 5'b00000 || vrm_sp_mv !== 16'(VRST)) begin
            n_fail++;
            $display("FAIL rst_mid_after flags/sp got %b/%0d want 00000/%0d",
                     {vrm_sp_vld, busy, done, err, overrun}, vrm_sp_mv, VRST);
        end
        m_sp = VRST;
    endtask

    task automatic test_random;
        for (int i = 0; i < 8; i++) begin
            int d, v, pg, ab, tk;
            d  = $urandom_range(0, 4);
            if ($urandom_range(0, 7) == 0) d = MAXD + 1;
            v  = $urandom_range(590, 1210);
            pg = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, TO - 1));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 400)) : -1;
            tk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 300)) : -1;
            run_cmd("random", d, v, pg, ab, tk);
        end
    endtask

    initial begin
        rst = 1'b1; trig_in = 1'b0; abort = 1'b0; vrm_pgood = 1'b0;
        delay_us = '0; voltage_mv = '0;
        test_reset;
        test_basic;
        test_odd_step;
        test_range;
        test_timeout;
        test_abort;
        test_overrun;
        test_rst_mid_delay;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired after %0d checks", n_chk);
        $fatal(1, "watchdog");
    end

endmodule
